// File: rtl/nco_pkg.sv
// Shared definitions for the NCO front end and m_cordic.
// Contents:
//   PHASE_W     - phase accumulator / angle width (full circle = 2^PHASE_W)
//   AMP_KINV    - Xin seed, 0.60725 * 2^15 (CORDIC gain pre-compensated)
//   nco_state_e - phase accumulator FTW-update state
//   QUAD_*      - quadrant codes carried in angle[PHASE_W-1 -: 2]
//   quadrant()  - extracts the quadrant field of a phase word
package nco_pkg;

    localparam int unsigned PHASE_W = 32;

    localparam logic signed [15:0] AMP_KINV = 16'sd19898;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } nco_state_e;

    localparam logic [1:0] QUAD_I   = 2'b00;
    localparam logic [1:0] QUAD_II  = 2'b01;
    localparam logic [1:0] QUAD_III = 2'b10;
    localparam logic [1:0] QUAD_IV  = 2'b11;

    function automatic logic [1:0] quadrant(input logic [PHASE_W-1:0] ang);
        return ang[PHASE_W-1 -: 2];
    endfunction

endpackage

// File: rtl/nco_phase_accumulator_if.sv
// Control / data bundle between the NCO phase accumulator and its surroundings.
// master: upstream controller plus the CORDIC consumer (drives enable, FTW handshake,
//         phase offset and clear; observes angle, seed vector, wrap, active FTW).
// slave : the phase accumulator itself.
// Signals:
//   enable      - accumulator advances while high
//   ftw_in      - new frequency tuning word, qualified by ftw_valid
//   ftw_valid   - ftw_in valid
//   ftw_ready   - accumulator can accept a tuning word
//   poff_in     - static phase offset, sampled every cycle
//   phase_clr   - synchronous accumulator clear
//   angle       - registered acc + poff_in, CORDIC angle input
//   angle_valid - registered enable
//   xin, yin    - constant CORDIC seed vector
//   wrap        - one-cycle pulse after an accumulator carry-out
//   ftw_active  - tuning word currently in use
interface nco_phase_accumulator_if #(
    parameter int unsigned PHASE_W = nco_pkg::PHASE_W
) ();

    logic                      enable;
    logic [PHASE_W-1:0]        ftw_in;
    logic                      ftw_valid;
    logic                      ftw_ready;
    logic [PHASE_W-1:0]        poff_in;
    logic                      phase_clr;
    logic signed [PHASE_W-1:0] angle;
    logic                      angle_valid;
    logic signed [15:0]        xin;
    logic signed [15:0]        yin;
    logic                      wrap;
    logic [PHASE_W-1:0]        ftw_active;

    modport master (
        output enable, ftw_in, ftw_valid, poff_in, phase_clr,
        input  ftw_ready, angle, angle_valid, xin, yin, wrap, ftw_active
    );

    modport slave (
        input  enable, ftw_in, ftw_valid, poff_in, phase_clr,
        output ftw_ready, angle, angle_valid, xin, yin, wrap, ftw_active
    );

endinterface

// File: rtl/nco_phase_accumulator.sv
// NCO phase accumulator: produces the phase word for m_cordic plus the constant
// Xin/Yin seed vector.
// Ports:
//   clock - rising-edge system clock
//   reset - asynchronous active-high reset
//   bus   - nco_phase_accumulator_if.slave (enable, FTW handshake, phase offset,
//           phase clear in; angle, angle_valid, xin, yin, wrap, ftw_active,
//           ftw_ready out)
// A captured FTW is held in a shadow register and becomes active either on the
// next accumulator carry (WRAP_UPDATE = 1, phase-continuous) or on the cycle after
// capture (WRAP_UPDATE = 0). phase_clr applies a pending FTW immediately.
module nco_phase_accumulator
    import nco_pkg::*;
#(
    parameter int unsigned        PHASE_W     = nco_pkg::PHASE_W,
    parameter logic signed [15:0] AMP         = nco_pkg::AMP_KINV,
    parameter logic [PHASE_W-1:0] FTW_RESET   = '0,
    parameter bit                 WRAP_UPDATE = 1'b1
) (
    input  logic                   clock,
    input  logic                   reset,
    nco_phase_accumulator_if.slave bus
);

    nco_state_e state_q, state_d;

    logic               pend_q, pend_d;
    logic [PHASE_W-1:0] shadow_q, shadow_d;
    logic [PHASE_W-1:0] ftw_q, ftw_d;
    logic [PHASE_W-1:0] acc_q, acc_d;
    logic [PHASE_W-1:0] angle_q, angle_d;
    logic               valid_q, valid_d;
    logic               wrap_q, wrap_d;

    logic [PHASE_W:0]   sum;
    logic               carry;
    logic               capture;
    logic               apply;

    // 33-bit add so the carry-out is available for wrap and the wrap-sync update.
    assign sum     = {1'b0, acc_q} + {1'b0, ftw_q};
    assign carry   = sum[PHASE_W];

    // ftw_ready is ~pend_q, so a capture and an apply never coincide.
    assign capture = bus.ftw_valid & ~pend_q;

    // phase_clr is a sync point for a pending FTW in any state; otherwise the
    // update only happens while running in PEND.
    assign apply   = pend_q &
                     (bus.phase_clr |
                      ((state_q == PEND) & bus.enable & (WRAP_UPDATE ? carry : 1'b1)));

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            pend_q   <= 1'b0;
            shadow_q <= '0;
            ftw_q    <= FTW_RESET;
            acc_q    <= '0;
            angle_q  <= '0;
            valid_q  <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pend_q   <= pend_d;
            shadow_q <= shadow_d;
            ftw_q    <= ftw_d;
            acc_q    <= acc_d;
            angle_q  <= angle_d;
            valid_q  <= valid_d;
            wrap_q   <= wrap_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        pend_d   = (pend_q | capture) & ~apply;
        shadow_d = shadow_q;
        ftw_d    = ftw_q;
        acc_d    = acc_q;
        wrap_d   = 1'b0;

        if (capture) begin
            shadow_d = bus.ftw_in;
        end

        if (apply) begin
            ftw_d = shadow_q;
        end

        // The carrying addition itself still uses the old FTW.
        if (bus.phase_clr) begin
            acc_d = '0;
        end else if (bus.enable) begin
            acc_d  = sum[PHASE_W-1:0];
            wrap_d = carry;
        end

        unique case (state_q)
            IDLE: begin
                if (bus.enable) begin
                    state_d = pend_d ? PEND : RUN;
                end
            end
            RUN: begin
                if (!bus.enable) begin
                    state_d = IDLE;
                end else if (pend_d) begin
                    state_d = PEND;
                end
            end
            PEND: begin
                if (!bus.enable) begin
                    state_d = IDLE;
                end else if (!pend_d) begin
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase

        // A clear may have resolved (or a capture created) the pending FTW.
        if (bus.phase_clr) begin
            state_d = !bus.enable ? IDLE : (pend_d ? PEND : RUN);
        end
    end

    // Output path: angle is sampled from the current acc, so it trails acc by one.
    assign angle_d = acc_q + bus.poff_in;
    assign valid_d = bus.enable;

    // Output logic
    always_comb begin
        bus.ftw_ready   = ~pend_q;
        bus.angle       = angle_q;
        bus.angle_valid = valid_q;
        bus.xin         = AMP;
        bus.yin         = 16'sd0;
        bus.wrap        = wrap_q;
        bus.ftw_active  = ftw_q;
    end

endmodule
